// File: rtl/char_box_overlay_pkg.sv
// char_seg_pkg: shared types and helpers for the character-box overlay.
//   NUM_BOX  number of character boxes published by the projection stage
//   COORD_W  width of every pixel coordinate
//   coord_t  one coordinate; ext_t is one bit wider so edge arithmetic never wraps
//   box_t    left/right column pair of one box
//   box_ok   horizontal validity of a box: ordered, wide enough, on screen
package char_seg_pkg;

  localparam int NUM_BOX = 8;
  localparam int COORD_W = 12;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [COORD_W:0]   ext_t;

  typedef struct packed {
    coord_t l;
    coord_t r;
  } box_t;

  function automatic logic box_ok(input coord_t l, input coord_t r,
                                  input ext_t img_w, input ext_t min_w);
    ext_t w;
    w = ext_t'(r) - ext_t'(l) + ext_t'(1);
    return (l < r) && (w >= min_w) && (ext_t'(r) < img_w);
  endfunction

endpackage

// File: rtl/char_box_hit.sv
// char_box_hit: decides, one pixel at a time, whether the pixel lies on the
// border of a single character box. Output is registered (pipeline stage 1).
// Optional feature macro: BOX_INDEX_TICK_EN adds a short tick of BOX_NUM pixels
// just inside the top-left corner so each box can be identified on screen.
//   pixelclk, reset      clock, async active-high reset
//   valid                box is valid for the current frame
//   box                  shadowed left/right columns
//   vl, vr               shadowed top/bottom rows (shared by all boxes)
//   top_edge, bot_edge   last row of top border / first row of bottom border
//   h, v                 coordinates of the incoming pixel
//   hit                  pixel must be painted with the border colour
module char_box_hit
  import char_seg_pkg::*;
#(
  parameter int BORDER_T = 2
`ifdef BOX_INDEX_TICK_EN
  , parameter int BOX_NUM = 1
`endif
)(
  input  logic   pixelclk,
  input  logic   reset,
  input  logic   valid,
  input  box_t   box,
  input  coord_t vl,
  input  coord_t vr,
  input  ext_t   top_edge,
  input  ext_t   bot_edge,
  input  coord_t h,
  input  coord_t v,
  output logic   hit
);

  localparam ext_t BT1 = ext_t'(BORDER_T - 1);

  ext_t l_x, r_x, h_x, v_x, lo_edge, ri_edge;
  logic in_box, on_border, mark;

  assign l_x = ext_t'(box.l);
  assign r_x = ext_t'(box.r);
  assign h_x = ext_t'(h);
  assign v_x = ext_t'(v);

  // Right edge clamps at column 0 so a box narrower than the border fills solid.
  assign lo_edge = l_x + BT1;
  assign ri_edge = (r_x >= BT1) ? r_x - BT1 : '0;

  assign in_box    = (v >= vl) && (v <= vr) && (h >= box.l) && (h <= box.r);
  assign on_border = (h_x <= lo_edge) || (h_x >= ri_edge) ||
                     (v_x <= top_edge) || (v_x >= bot_edge);

`ifdef BOX_INDEX_TICK_EN
  localparam ext_t BT = ext_t'(BORDER_T);
  logic tick;
  assign tick = (v_x == ext_t'(vl) + BT) && (h_x >= l_x + BT) &&
                (h_x < l_x + BT + ext_t'(BOX_NUM));
  assign mark = on_border || tick;
`else
  assign mark = on_border;
`endif

  always_ff @(posedge pixelclk or posedge reset) begin
    if (reset) hit <= 1'b0;
    else       hit <= valid && in_box && mark;
  end

endmodule

// File: rtl/char_box_overlay.sv
// char_box_overlay: latches the eight character boxes published by the
// segmentation stage once per frame and draws a solid border around every
// valid box on the live RGB stream. Latency is 2 pixel clocks on all outputs.
// Optional feature macro: BOX_INDEX_TICK_EN (box-number tick inside each box).
//   pixelclk, reset                  clock, async active-high reset
//   i_rgb, i_hs, i_vs, i_de          input video
//   i_hcount, i_vcount               coordinates of i_rgb
//   hcount_l1..8, hcount_r1..8       left/right column of box 1..8
//   vcount_l, vcount_r               shared top/bottom row
//   o_rgb, o_hs, o_vs, o_de          output video, 2 cycles behind input
//   o_box_valid                      bit k-1 set when box k is drawn this frame
module char_box_overlay
  import char_seg_pkg::*;
#(
  parameter int                        IMG_WIDTH_LINE = 1920,
  parameter int                        IMG_WIDTH_DATA = 24,
  parameter int                        BORDER_T       = 2,
  parameter int                        MIN_W          = 4,
  parameter logic [IMG_WIDTH_DATA-1:0] BOX_COLOR      = 24'hFF0000
)(
  input  logic                      pixelclk,
  input  logic                      reset,
  input  logic [IMG_WIDTH_DATA-1:0] i_rgb,
  input  logic                      i_hs,
  input  logic                      i_vs,
  input  logic                      i_de,
  input  logic [COORD_W-1:0]        i_hcount,
  input  logic [COORD_W-1:0]        i_vcount,
  input  logic [COORD_W-1:0]        hcount_l1, hcount_l2, hcount_l3, hcount_l4,
  input  logic [COORD_W-1:0]        hcount_l5, hcount_l6, hcount_l7, hcount_l8,
  input  logic [COORD_W-1:0]        hcount_r1, hcount_r2, hcount_r3, hcount_r4,
  input  logic [COORD_W-1:0]        hcount_r5, hcount_r6, hcount_r7, hcount_r8,
  input  logic [COORD_W-1:0]        vcount_l,
  input  logic [COORD_W-1:0]        vcount_r,
  output logic [IMG_WIDTH_DATA-1:0] o_rgb,
  output logic                      o_hs,
  output logic                      o_vs,
  output logic                      o_de,
  output logic [NUM_BOX-1:0]        o_box_valid
);

  localparam ext_t BT1 = ext_t'(BORDER_T - 1);

  box_t   box_in [NUM_BOX];
  box_t   box_sh [NUM_BOX];
  coord_t vl_sh, vr_sh;
  logic   vs_r, cap, cap_d;
  logic [NUM_BOX-1:0] valid_next, hit;
  ext_t   top_edge, bot_edge;
  logic [IMG_WIDTH_DATA-1:0] rgb_d1;
  logic   hs_d1, vs_d1, de_d1;

  assign box_in[0] = {hcount_l1, hcount_r1};
  assign box_in[1] = {hcount_l2, hcount_r2};
  assign box_in[2] = {hcount_l3, hcount_r3};
  assign box_in[3] = {hcount_l4, hcount_r4};
  assign box_in[4] = {hcount_l5, hcount_r5};
  assign box_in[5] = {hcount_l6, hcount_r6};
  assign box_in[6] = {hcount_l7, hcount_r7};
  assign box_in[7] = {hcount_l8, hcount_r8};

  // Upstream refreshes its boundaries on the vs rising-edge cycle, so the
  // capture strobe runs one cycle behind the edge; validity follows a cycle later.
  always_ff @(posedge pixelclk or posedge reset) begin
    if (reset) begin
      vs_r        <= 1'b0;
      cap         <= 1'b0;
      cap_d       <= 1'b0;
      vl_sh       <= '0;
      vr_sh       <= '0;
      o_box_valid <= '0;
      for (int k = 0; k < NUM_BOX; k++) box_sh[k] <= '0;
    end else begin
      vs_r  <= i_vs;
      cap   <= i_vs & ~vs_r;
      cap_d <= cap;
      if (cap) begin
        box_sh <= box_in;
        vl_sh  <= vcount_l;
        vr_sh  <= vcount_r;
      end
      if (cap_d) o_box_valid <= valid_next;
    end
  end

  always_comb begin
    valid_next = '0;
    for (int k = 0; k < NUM_BOX; k++)
      valid_next[k] = box_ok(box_sh[k].l, box_sh[k].r,
                             ext_t'(IMG_WIDTH_LINE), ext_t'(MIN_W)) &&
                      (vl_sh < vr_sh);
  end

  assign top_edge = ext_t'(vl_sh) + BT1;
  assign bot_edge = (ext_t'(vr_sh) >= BT1) ? ext_t'(vr_sh) - BT1 : '0;

  for (genvar k = 0; k < NUM_BOX; k++) begin : g_box
    char_box_hit #(
      .BORDER_T(BORDER_T)
`ifdef BOX_INDEX_TICK_EN
      , .BOX_NUM(k + 1)
`endif
    ) u_hit (
      .pixelclk (pixelclk),
      .reset    (reset),
      .valid    (o_box_valid[k]),
      .box      (box_sh[k]),
      .vl       (vl_sh),
      .vr       (vr_sh),
      .top_edge (top_edge),
      .bot_edge (bot_edge),
      .h        (i_hcount),
      .v        (i_vcount),
      .hit      (hit[k])
    );
  end

  // Stage 1 delays the video alongside the hit registers; stage 2 muxes.
  always_ff @(posedge pixelclk or posedge reset) begin
    if (reset) begin
      rgb_d1 <= '0;
      hs_d1  <= 1'b0;
      vs_d1  <= 1'b0;
      de_d1  <= 1'b0;
      o_rgb  <= '0;
      o_hs   <= 1'b0;
      o_vs   <= 1'b0;
      o_de   <= 1'b0;
    end else begin
      rgb_d1 <= i_rgb;
      hs_d1  <= i_hs;
      vs_d1  <= i_vs;
      de_d1  <= i_de;
      o_rgb  <= (|hit && de_d1) ? BOX_COLOR : rgb_d1;
      o_hs   <= hs_d1;
      o_vs   <= vs_d1;
      o_de   <= de_d1;
    end
  end

endmodule

// File: tb/tb_char_box_overlay.sv
// Bench for char_box_overlay: random pixels around the programmed boxes,
// checked against a frame-level reference model of the drawing rules.
module tb_char_box_overlay;

  localparam int          BT    = 2;
  localparam int          MINW  = 4;
  localparam int          IMGW  = 1920;
  localparam logic [23:0] COLOR = 24'hFF0000;

  typedef struct packed {
    logic [23:0] rgb;
    logic        hs;
    logic        vs;
    logic        de;
  } vid_t;

  logic        pixelclk = 1'b0;
  logic        reset;
  logic [23:0] i_rgb;
  logic        i_hs, i_vs, i_de;
  logic [11:0] i_hcount, i_vcount;
  logic [11:0] bl [8];
  logic [11:0] br [8];
  logic [11:0] bvl, bvr;
  logic [23:0] o_rgb;
  logic        o_hs, o_vs, o_de;
  logic [7:0]  o_box_valid;

  int   nl [8], nr [8], nvl, nvr;
  int   ml [8], mr [8], mvl, mvr;
  bit   mvalid [8];
  bit   m_vs_prev, m_cap_pending;
  vid_t exp_q [$];
  int   errors = 0, checks = 0;

  always #5 pixelclk = ~pixelclk;

  char_box_overlay dut (
    .pixelclk(pixelclk), .reset(reset),
    .i_rgb(i_rgb), .i_hs(i_hs), .i_vs(i_vs), .i_de(i_de),
    .i_hcount(i_hcount), .i_vcount(i_vcount),
    .hcount_l1(bl[0]), .hcount_l2(bl[1]), .hcount_l3(bl[2]), .hcount_l4(bl[3]),
    .hcount_l5(bl[4]), .hcount_l6(bl[5]), .hcount_l7(bl[6]), .hcount_l8(bl[7]),
    .hcount_r1(br[0]), .hcount_r2(br[1]), .hcount_r3(br[2]), .hcount_r4(br[3]),
    .hcount_r5(br[4]), .hcount_r6(br[5]), .hcount_r7(br[6]), .hcount_r8(br[7]),
    .vcount_l(bvl), .vcount_r(bvr),
    .o_rgb(o_rgb), .o_hs(o_hs), .o_vs(o_vs), .o_de(o_de),
    .o_box_valid(o_box_valid)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic void model_latch();
    mvl = int'(bvl);
    mvr = int'(bvr);
    for (int k = 0; k < 8; k++) begin
      ml[k] = int'(bl[k]);
      mr[k] = int'(br[k]);
      mvalid[k] = (ml[k] < mr[k]) && (mr[k] - ml[k] + 1 >= MINW) &&
                  (mr[k] < IMGW) && (mvl < mvr);
    end
  endfunction

  function automatic logic [7:0] model_valid_vec();
    logic [7:0] v;
    v = '0;
    for (int k = 0; k < 8; k++) v[k] = mvalid[k];
    return v;
  endfunction

  // A pixel is on the border if it is inside a valid box and closer than
  // BT pixels to any of its four sides.
  function automatic bit model_hit(int h, int v);
    for (int k = 0; k < 8; k++)
      if (mvalid[k] && h >= ml[k] && h <= mr[k] && v >= mvl && v <= mvr &&
          (h - ml[k] < BT || mr[k] - h < BT || v - mvl < BT || mvr - v < BT))
        return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 8; k++) mvalid[k] = 1'b0;
    m_vs_prev     = 1'b0;
    m_cap_pending = 1'b0;
    exp_q.delete();
  endfunction

  // ---------------- stimulus plumbing ----------------
  function automatic vid_t rand_pix(bit de);
    vid_t p;
    p.rgb = 24'($urandom());
    p.hs  = 1'($urandom());
    p.vs  = 1'b0;
    p.de  = de;
    return p;
  endfunction

  task automatic rand_coord(output int h, output int v);
    int k, lo, hi, t;
    k  = $urandom_range(7, 0);
    lo = int'(bl[k]);
    hi = int'(br[k]);
    if (lo > hi) begin t = lo; lo = hi; hi = t; end
    if ($urandom_range(4, 0) == 0) begin
      h = $urandom_range(1919, 0);
      v = $urandom_range(1079, 0);
    end else begin
      h = lo - 3 + int'($urandom_range(hi - lo + 6, 0));
      lo = int'(bvl);
      hi = int'(bvr);
      if (lo > hi) begin t = lo; lo = hi; hi = t; end
      v = lo - 3 + int'($urandom_range(hi - lo + 6, 0));
    end
    if (h < 0) h = 0;
    if (h > 1919) h = 1919;
    if (v < 0) v = 0;
    if (v > 1123) v = 1123;
  endtask

  // Applies one cycle of input, records its expected output, and returns
  // the output now due (the pixel applied on the previous call).
  task automatic step(input vid_t vin, input int h, input int v,
                      output vid_t got, output vid_t want, output bit have);
    vid_t e;
    bit   rise;
    i_rgb = vin.rgb; i_hs = vin.hs; i_vs = vin.vs; i_de = vin.de;
    i_hcount = 12'(h); i_vcount = 12'(v);
    if (m_cap_pending) model_latch();
    rise          = vin.vs && !m_vs_prev;
    m_vs_prev     = vin.vs;
    m_cap_pending = rise;
    e = vin;
    if (vin.de && model_hit(h, v)) e.rgb = COLOR;
    exp_q.push_back(e);
    @(posedge pixelclk); #1;
    have = 1'b0; got = '0; want = '0;
    if (exp_q.size() >= 2) begin
      want = exp_q.pop_front();
      got  = {o_rgb, o_hs, o_vs, o_de};
      have = 1'b1;
    end
  endtask

  // Vertical blanking: vs rises with the old boundaries on the bus, then the
  // upstream stage publishes the next-frame boundaries one cycle later.
  task automatic frame_start();
    vid_t z, g, w;
    bit hv;
    z = '0;
    step(z, 0, 0, g, w, hv);
    step(z, 0, 0, g, w, hv);
    z.vs = 1'b1;
    step(z, 0, 0, g, w, hv);
    for (int k = 0; k < 8; k++) begin bl[k] = 12'(nl[k]); br[k] = 12'(nr[k]); end
    bvl = 12'(nvl); bvr = 12'(nvr);
    step(z, 0, 0, g, w, hv);
    step(z, 0, 0, g, w, hv);
    z.vs = 1'b0;
    repeat (3) step(z, 0, 0, g, w, hv);
  endtask

  task automatic clear_next();
    for (int k = 0; k < 8; k++) begin nl[k] = 0; nr[k] = 0; end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge pixelclk);
    #1;
    checks++;
    if ({o_rgb, o_hs, o_vs, o_de, o_box_valid} !== '0) begin
      errors++;
      $display("FAIL reset_state got=%h want=0", {o_rgb, o_hs, o_vs, o_de, o_box_valid});
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_basic_box();
    int          ph [7] = '{100, 149, 120, 120, 102, 120, 100};
    int          pv [7] = '{520, 520, 500, 559, 520, 502, 521};
    bit          pd [7] = '{1, 1, 1, 1, 1, 1, 0};
    logic [23:0] wc [7] = '{24'hFF0000, 24'hFF0000, 24'hFF0000, 24'hFF0000,
                            24'h123456, 24'h123456, 24'h123456};
    vid_t p, g, w;
    bit hv;
    clear_next();
    nl[0] = 100; nr[0] = 149; nvl = 500; nvr = 559;
    frame_start();
    checks++;
    if (o_box_valid !== 8'h01) begin
      errors++;
      $display("FAIL basic_valid got=%h want=01", o_box_valid);
    end
    for (int i = 0; i < 8; i++) begin
      p = '0;
      if (i < 7) begin p.rgb = 24'h123456; p.de = pd[i]; step(p, ph[i], pv[i], g, w, hv); end
      else step(p, 0, 0, g, w, hv);
      if (i >= 1 && hv) begin
        checks++;
        if (g.rgb !== wc[i-1] || g !== w) begin
          errors++;
          $display("FAIL basic_pixel%0d got=%h want_rgb=%h model=%h", i - 1, g, wc[i-1], w);
        end
      end
    end
  endtask

  task automatic test_invalid();
    vid_t g, w;
    bit hv;
    int h, v;
    nl[1] = 200; nr[1] = 202;
    nl[2] = 300; nr[2] = 2000;
    nl[3] = 400; nr[3] = 403;
    frame_start();
    checks++;
    if (o_box_valid !== 8'h09 || o_box_valid !== model_valid_vec()) begin
      errors++;
      $display("FAIL invalid_valid got=%h want=09", o_box_valid);
    end
    for (int i = 0; i < 300; i++) begin
      rand_coord(h, v);
      step(rand_pix($urandom_range(9, 0) != 0), h, v, g, w, hv);
      if (hv) begin
        checks++;
        if (g !== w) begin errors++; $display("FAIL invalid_pix got=%h want=%h", g, w); end
      end
    end
  endtask

  task automatic test_update_on_rise();
    vid_t g, w;
    bit hv;
    int h, v;
    clear_next();
    nl[0] = 100; nr[0] = 101;
    nl[1] = 600; nr[1] = 700;
    nvl = 500; nvr = 559;
    frame_start();
    checks++;
    if (o_box_valid !== 8'h02) begin
      errors++;
      $display("FAIL rise_update_valid got=%h want=02", o_box_valid);
    end
    for (int i = 0; i < 250; i++) begin
      rand_coord(h, v);
      step(rand_pix($urandom_range(9, 0) != 0), h, v, g, w, hv);
      if (hv) begin
        checks++;
        if (g !== w) begin errors++; $display("FAIL rise_update_pix got=%h want=%h", g, w); end
      end
    end
  endtask

  task automatic test_mid_frame_change();
    vid_t g, w;
    bit hv;
    int h, v;
    for (int i = 0; i < 330; i++) begin
      if (i == 80) begin
        bl[0] = 12'd1000; br[0] = 12'd1050; bl[1] = 12'd800; br[1] = 12'd900;
        bvl = 12'd100; bvr = 12'd150;
        nl[0] = 1000; nr[0] = 1050; nl[1] = 800; nr[1] = 900; nvl = 100; nvr = 150;
      end
      rand_coord(h, v);
      step(rand_pix($urandom_range(9, 0) != 0), h, v, g, w, hv);
      if (hv) begin
        checks++;
        if (g !== w) begin errors++; $display("FAIL mid_change_pix got=%h want=%h", g, w); end
      end
    end
    checks++;
    if (o_box_valid !== 8'h02) begin
      errors++;
      $display("FAIL mid_change_hold got=%h want=02", o_box_valid);
    end
    frame_start();
    checks++;
    if (o_box_valid !== 8'h03) begin
      errors++;
      $display("FAIL mid_change_next got=%h want=03", o_box_valid);
    end
    for (int i = 0; i < 250; i++) begin
      rand_coord(h, v);
      step(rand_pix($urandom_range(9, 0) != 0), h, v, g, w, hv);
      if (hv) begin
        checks++;
        if (g !== w) begin errors++; $display("FAIL next_frame_pix got=%h want=%h", g, w); end
      end
    end
  endtask

  task automatic test_random_frames();
    vid_t g, w;
    bit hv;
    int h, v, sel;
    for (int f = 0; f < 5; f++) begin
      for (int k = 0; k < 8; k++) begin
        nl[k] = $urandom_range(1800, 0);
        sel = $urandom_range(9, 0);
        if (sel == 0)      nr[k] = nl[k] - 1;
        else if (sel == 1) nr[k] = 1920 + $urandom_range(50, 0);
        else               nr[k] = nl[k] + $urandom_range(80, 0);
      end
      nvl = $urandom_range(1000, 0);
      nvr = ($urandom_range(7, 0) == 0) ? nvl : nvl + $urandom_range(80, 1);
      frame_start();
      checks++;
      if (o_box_valid !== model_valid_vec()) begin
        errors++;
        $display("FAIL rand_valid got=%h want=%h", o_box_valid, model_valid_vec());
      end
      for (int i = 0; i < 300; i++) begin
        rand_coord(h, v);
        step(rand_pix($urandom_range(9, 0) != 0), h, v, g, w, hv);
        if (hv) begin
          checks++;
          if (g !== w) begin errors++; $display("FAIL rand_pix got=%h want=%h", g, w); end
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    vid_t g, w;
    bit hv;
    int h, v;
    clear_next();
    nl[0] = 100; nr[0] = 149; nl[4] = 300; nr[4] = 360; nvl = 500; nvr = 559;
    frame_start();
    for (int i = 0; i < 40; i++) begin
      rand_coord(h, v);
      step(rand_pix(1'b1), h, 540, g, w, hv);
    end
    i_rgb = 24'hABCDEF; i_hs = 1'b1; i_de = 1'b1;
    reset = 1'b1;
    #1;
    checks++;
    if ({o_rgb, o_hs, o_vs, o_de, o_box_valid} !== '0) begin
      errors++;
      $display("FAIL reset_mid_immediate got=%h want=0", {o_rgb, o_hs, o_vs, o_de, o_box_valid});
    end
    @(posedge pixelclk); #1;
    checks++;
    if ({o_rgb, o_hs, o_vs, o_de, o_box_valid} !== '0) begin
      errors++;
      $display("FAIL reset_mid_held got=%h want=0", {o_rgb, o_hs, o_vs, o_de, o_box_valid});
    end
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 200; i++) begin
      rand_coord(h, v);
      step(rand_pix($urandom_range(9, 0) != 0), h, v, g, w, hv);
      if (hv) begin
        checks++;
        if (g !== w) begin errors++; $display("FAIL post_reset_pix got=%h want=%h", g, w); end
      end
    end
    checks++;
    if (o_box_valid !== 8'h00) begin
      errors++;
      $display("FAIL post_reset_valid got=%h want=00", o_box_valid);
    end
    frame_start();
    checks++;
    if (o_box_valid !== 8'h11) begin
      errors++;
      $display("FAIL reset_next_frame got=%h want=11", o_box_valid);
    end
  endtask

  task automatic test_vs_at_release();
    vid_t z, g, w;
    bit hv;
    int h, v;
    clear_next();
    nl[0] = 100; nr[0] = 149; nvl = 500; nvr = 559;
    for (int k = 0; k < 8; k++) begin bl[k] = 12'(nl[k]); br[k] = 12'(nr[k]); end
    bvl = 12'(nvl); bvr = 12'(nvr);
    i_vs = 1'b1; i_de = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge pixelclk);
    #1;
    reset = 1'b0;
    model_reset();
    z = '0; z.vs = 1'b1;
    repeat (3) step(z, 0, 0, g, w, hv);
    z.vs = 1'b0;
    repeat (3) step(z, 0, 0, g, w, hv);
    checks++;
    if (o_box_valid !== 8'h01 || o_box_valid !== model_valid_vec()) begin
      errors++;
      $display("FAIL vs_release_valid got=%h want=01", o_box_valid);
    end
    for (int i = 0; i < 200; i++) begin
      rand_coord(h, v);
      step(rand_pix($urandom_range(9, 0) != 0), h, v, g, w, hv);
      if (hv) begin
        checks++;
        if (g !== w) begin errors++; $display("FAIL vs_release_pix got=%h want=%h", g, w); end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    i_rgb = '0; i_hs = 1'b0; i_vs = 1'b0; i_de = 1'b0;
    i_hcount = '0; i_vcount = '0;
    for (int k = 0; k < 8; k++) begin bl[k] = '0; br[k] = '0; end
    bvl = '0; bvr = '0;
    clear_next();
    nvl = 0; nvr = 0;
    test_reset();
    test_basic_box();
    test_invalid();
    test_update_on_rise();
    test_mid_frame_change();
    test_random_frames();
    test_reset_mid_frame();
    test_vs_at_release();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/char_box_overlay.md
# char_box_overlay

Downstream consumer of the character-segmentation projection stage. Takes the eight column-boundary pairs and the single row-boundary pair that stage publishes, latches them once per frame, validates each box, and draws a solid-colour rectangular border around every valid character box on the live RGB stream. Output feeds the HDMI/VGA output path for on-screen segmentation debug and demo.

## Interface
- IMG_WIDTH_LINE, 1920, active pixels per line; boxes with any coordinate >= this are invalid
- IMG_WIDTH_DATA, 24, pixel data width
- BORDER_T, 2, border thickness in pixels (1..15)
- MIN_W, 4, minimum box width (r-l+1) for a box to be valid
- BOX_COLOR, 24'hFF0000, border pixel value
- pixelclk  in  1  pixel clock, the only clock
- reset  in  1  asynchronous, active-high reset
- i_rgb  in  IMG_WIDTH_DATA  input pixel
- i_hs, i_vs, i_de  in  1 each  input syncs / data enable
- i_hcount, i_vcount  in  12 each  coordinates of i_rgb
- hcount_l1..hcount_l8  in  12 each  box k left column
- hcount_r1..hcount_r8  in  12 each  box k right column
- vcount_l, vcount_r  in  12 each  shared top / bottom row
- o_rgb  out  IMG_WIDTH_DATA  output pixel
- o_hs, o_vs, o_de  out  1 each  delayed syncs
- o_box_valid  out  8  bit k-1 = box k valid for current frame

## Operation
- vs_rise = i_vs & !vs_r. Capture strobe cap = vs_rise delayed one cycle; upstream updates its boundary outputs on the vs_rise cycle, so capture must be one cycle later.
- On cap: load all 18 boundary inputs into shadow registers.
- Cycle after cap: o_box_valid[k] <= (l_k < r_k) && (r_k - l_k + 1 >= MIN_W) && (r_k < IMG_WIDTH_LINE) && (vcount_l < vcount_r). Held until next frame.
- Arithmetic in 13 bits, no wrap: lo_edge = l + BORDER_T - 1; ri_edge = (r >= BORDER_T-1) ? r - BORDER_T + 1 : 0; same for top/bottom using vcount_l/vcount_r.
- Hit for box k (stage 1, registered): valid[k] && vl <= v <= vr && l <= h <= r && (h <= lo_edge || h >= ri_edge || v <= top_edge || v >= bot_edge).
- Stage 2: any_hit = OR of 8 hits; o_rgb = (any_hit && de_d1) ? BOX_COLOR : rgb_d1. Overlapping boxes: same colour, no priority.
- Box with BORDER_T*2 >= width: fully filled (edges overlap) — legal.
- Pixels with de low are never recoloured.

## Timing
- Latency: exactly 2 cycles from i_* to o_*, all of o_rgb/o_hs/o_vs/o_de identically aligned.
- Boundaries take effect from the first active line after the vs rising edge; mid-frame input changes ignored.
- Reset (async): o_rgb, o_hs, o_vs, o_de, o_box_valid, shadows, pipeline all 0. After release, video passes through unmodified (valid = 0) until the first cap plus one cycle.
- Reset mid-frame: outputs zero immediately; no partial boxes drawn on the remainder of that frame.
- vs_rise on first cycle after reset release: vs_r resets to 0, so an i_vs already high produces a capture — required.

## Configuration
- BOX_INDEX_TICK_EN defined: additionally draws, inside each valid box, a tick of k pixels (box number) on row vcount_l + BORDER_T, starting at column l + BORDER_T, same colour, same 2-cycle latency.
- Undefined: borders only; no tick logic synthesised.

## Structure
- Package char_seg_pkg: NUM_BOX = 8, COORD_W = 12, box_t {l, r : COORD_W}, validity function box_ok(l, r, img_w, min_w).
- Sub-module char_box_hit: one per box (8 instances), inputs shadow l/r, shared edges, h/v, valid; registered hit output (stage 1).
- Top holds edge detect, shadows, validity, OR-reduce and output mux.

## Test plan
- 1920x1080 frame, box1 l=100 r=149, vl=500 vr=559, BORDER_T=2 -> pixels (100,520),(149,520),(120,500),(120,559) = FF0000; (102,520) and (120,502) unchanged; o_box_valid=8'h01.
- l=200 r=202 (width 3 < MIN_W) -> box not drawn, o_box_valid bit clear; r=2000 -> invalid.
- Change boundary inputs mid-frame (line 600) -> current frame unchanged; new box appears next frame after vs rise.
- Upstream updates boundaries on the vs_rise cycle -> new values captured, not the previous ones.
- Assert reset at line 540 -> all outputs 0 during reset; after release pass-through with o_box_valid=0 until next vs rise +2 cycles.
- Compare o_* against i_* delayed 2 cycles for pixels with no hit and for de low -> bit-exact match.
